// File: rtl/seq_multiplier_if.sv
// Operand/product handshake bundle for seq_multiplier: an operand valid/ready
// channel in and a product valid/ready channel out.
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier: one ripple-carry partial-product add per clock.
// Optional build macro SEQ_MULTIPLIER_ZERO_SKIP_EN: zero operands bypass RUN and go straight to DONE.
module RippleCarryAdder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];
endmodule

module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] product_r;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [2*WIDTH-1:0] shifted;
    logic               zero_op;

    assign add_b   = acc_lo[0] ? mcand : '0;
    assign shifted = {cout, sum, acc_lo[WIDTH-1:1]};

`ifdef SEQ_MULTIPLIER_ZERO_SKIP_EN
    assign zero_op = (bus.a == '0) || (bus.b == '0);
`else
    assign zero_op = 1'b0;
`endif

    RippleCarryAdder #(.WIDTH(WIDTH)) u_adder (
        .a    (acc_hi),
        .b    (add_b),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    // Handshake outputs decode state only, so no input reaches them combinationally.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.product   = product_r;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.in_valid)  next_state = zero_op ? DONE : RUN;
            RUN:  if (cnt == LAST)   next_state = DONE;
            DONE: if (bus.out_ready) next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
            product_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand  <= bus.a;
                        acc_hi <= '0;
                        cnt    <= '0;
                        if (zero_op) begin
                            acc_lo    <= '0;
                            product_r <= '0;
                        end else begin
                            acc_lo <= bus.b;
                        end
                    end
                end
                RUN: begin
                    acc_hi <= shifted[2*WIDTH-1:WIDTH];
                    acc_lo <= shifted[WIDTH-1:0];
                    cnt    <= cnt + 1'b1;
                    // Product is captured once so it holds through IDLE and the next RUN.
                    if (cnt == LAST) product_r <= shifted;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=8): directed vector table, back-pressure,
// mid-run reset and a back-to-back random stream against a product scoreboard.
module tb_seq_multiplier;
    localparam int W = 8;
`ifdef SEQ_MULTIPLIER_ZERO_SKIP_EN
    localparam int ZLAT = 0;   // zero operand: DONE is entered on the accepting edge itself
`else
    localparam int ZLAT = W;
`endif

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
        int             lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(W)) mif ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge where out_valid is first seen.
    // lat counts clock edges after the accepting edge; low counts sampled cycles with in_ready=0.
    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                         output int lat, output int low, output bit timed_out);
        lat = -1;
        low = 0;
        timed_out = 1'b1;
        mif.a = va;
        mif.b = vb;
        mif.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            if (!mif.in_ready) low++;
            if (mif.out_valid) begin
                lat = i;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    vec_t           vecs[8];
    int             lat;
    int             low;
    bit             to;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] pexp;
    int             acc_n;
    int             got_n;
    int             cyc;
    int             last_acc;
    bit             fire_in;
    bit             fire_out;

    initial begin
        vecs[0] = '{a: 8'd13,  b: 8'd11,  exp: 16'd143,   lat: W};
        vecs[1] = '{a: 8'd255, b: 8'd255, exp: 16'hFE01,  lat: W};
        vecs[2] = '{a: 8'd128, b: 8'd2,   exp: 16'd256,   lat: W};
        vecs[3] = '{a: 8'd0,   b: 8'd200, exp: 16'd0,     lat: ZLAT};
        vecs[4] = '{a: 8'd1,   b: 8'd1,   exp: 16'd1,     lat: W};
        vecs[5] = '{a: 8'd255, b: 8'd1,   exp: 16'd255,   lat: W};
        vecs[6] = '{a: 8'd170, b: 8'd85,  exp: 16'd14450, lat: W};
        vecs[7] = '{a: 8'd1,   b: 8'd255, exp: 16'd255,   lat: W};

        rst_n = 1'b0;
        mif.in_valid = 1'b0;
        mif.out_ready = 1'b0;
        mif.a = '0;
        mif.b = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", mif.in_ready, 1);
        check("reset_out_valid", mif.out_valid, 0);
        check("reset_product", mif.product, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hold_in_ready", mif.in_ready, 1);

        // Directed table with the consumer always ready.
        mif.out_ready = 1'b1;
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, lat, low, to);
            check($sformatf("vec%0d_timeout", i), to, 0);
            check($sformatf("vec%0d_product", i), mif.product, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_in_ready_low", i), low, vecs[i].lat + 1);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_back_idle", i), mif.in_ready, 1);
            check($sformatf("vec%0d_out_valid_drop", i), mif.out_valid, 0);
        end

        // Back-pressure: DONE holds while out_ready=0; in_valid pulses must not be taken.
        mif.out_ready = 1'b0;
        do_op(8'd13, 8'd11, lat, low, to);
        check("bp_timeout", to, 0);
        for (int i = 0; i < 5; i++) begin
            mif.in_valid = i[0];
            mif.a = 8'(i + 50);
            mif.b = 8'(i + 60);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_out_valid_%0d", i), mif.out_valid, 1);
            check($sformatf("bp_product_%0d", i), mif.product, 143);
            check($sformatf("bp_in_ready_%0d", i), mif.in_ready, 0);
        end
        mif.in_valid = 1'b0;
        mif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_in_ready", mif.in_ready, 1);
        check("bp_release_out_valid", mif.out_valid, 0);
        check("bp_product_held_in_idle", mif.product, 143);

        // Reset four clocks into RUN aborts the operation asynchronously.
        mif.a = 8'd200;
        mif.b = 8'd200;
        mif.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", mif.in_ready, 1);
        check("abort_out_valid", mif.out_valid, 0);
        check("abort_product", mif.product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'd3, 8'd7, lat, low, to);
        check("post_abort_timeout", to, 0);
        check("post_abort_product", mif.product, 21);
        check("post_abort_latency", lat, W);
        @(posedge clk);
        @(negedge clk);

        // Back-to-back stream: in_valid held high, random out_ready, in-order scoreboard.
        acc_n = 0;
        got_n = 0;
        cyc = 0;
        last_acc = 0;
        mif.a = 8'($urandom_range(1, 255));
        mif.b = 8'($urandom_range(1, 255));
        mif.in_valid = 1'b1;
        while (got_n < 100 && cyc < 20000) begin
            mif.out_ready = 1'($urandom_range(0, 1));
            fire_in  = mif.in_valid && mif.in_ready;
            fire_out = mif.out_valid && mif.out_ready;
            if (fire_out) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_product", mif.product, 0);
                    check("rand_queue_underflow", 1, 0);
                end else begin
                    check($sformatf("rand_product_%0d", got_n), mif.product, exp_q.pop_front());
                end
                got_n++;
            end
            if (fire_in) begin
                pexp = (2*W)'(mif.a) * (2*W)'(mif.b);
                exp_q.push_back(pexp);
                if (acc_n > 0) check($sformatf("rand_interval_ge10_%0d", acc_n), (cyc - last_acc) >= 10, 1);
                last_acc = cyc;
                acc_n++;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (fire_in) begin
                if (acc_n == 100) begin
                    mif.in_valid = 1'b0;
                end else begin
                    mif.a = 8'($urandom_range(1, 255));
                    mif.b = 8'($urandom_range(1, 255));
                end
            end
        end
        check("rand_all_received", got_n, 100);
        check("rand_accepted", acc_n, 100);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
